// File: rtl/exec_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// exec_sequencer_pkg
//   Shared types and constants for the pico MIPS execution sequencer.
//   - seq_state_t : sequencer FSM states
//   - op_class_t  : coarse instruction class produced by the decoder
//   - OP_*        : instruction opcodes (6 bit)
//   - ALU_*       : ALU function codes (3 bit)
// ----------------------------------------------------------------------------
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    MUL_WAIT,
    IN_WAIT,
    OUT_WAIT
  } seq_state_t;

  localparam seq_state_t SEQ_IDLE_ST = IDLE;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULT,
    CLS_BRANCH,
    CLS_STIN,
    CLS_LOUT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MULT = 6'h04;
  localparam logic [5:0] OP_BEQ  = 6'h05;
  localparam logic [5:0] OP_BNQ  = 6'h06;
  localparam logic [5:0] OP_JMP  = 6'h07;
  localparam logic [5:0] OP_STIN = 6'h08;
  localparam logic [5:0] OP_LOUT = 6'h09;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_RADD = 3'b010;
  localparam logic [2:0] ALU_RSUB = 3'b110;

endpackage

// File: rtl/exec_sequencer_if.sv
// ----------------------------------------------------------------------------
// exec_sequencer_if
//   Bundles the decoder/datapath/IO side of the sequencer.
//   master : drives opcode, ZF, in_valid, out_ready (and step when
//            SEQ_SINGLE_STEP_EN is defined); observes the control outputs.
//   slave  : the sequencer itself.
//   Macro SEQ_SINGLE_STEP_EN adds the single-step request signal `step`.
// ----------------------------------------------------------------------------
interface exec_sequencer_if;

  logic [5:0] opcode;
  logic       ZF;
  logic       in_valid;
  logic       out_ready;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step;
`endif
  logic [2:0] alu_func;
  logic       immediate;
  logic       pc_en;
  logic       pc_rel_branch;
  logic       reg_write;
  logic       read_in;
  logic       write_out;
  logic       out_valid;
  logic       in_ack;
  logic       mul_start;
  logic       busy;
  logic       illegal_op;

`ifdef SEQ_SINGLE_STEP_EN
  modport master (
    output opcode, ZF, in_valid, out_ready, step,
    input  alu_func, immediate, pc_en, pc_rel_branch, reg_write, read_in,
           write_out, out_valid, in_ack, mul_start, busy, illegal_op
  );
  modport slave (
    input  opcode, ZF, in_valid, out_ready, step,
    output alu_func, immediate, pc_en, pc_rel_branch, reg_write, read_in,
           write_out, out_valid, in_ack, mul_start, busy, illegal_op
  );
`else
  modport master (
    output opcode, ZF, in_valid, out_ready,
    input  alu_func, immediate, pc_en, pc_rel_branch, reg_write, read_in,
           write_out, out_valid, in_ack, mul_start, busy, illegal_op
  );
  modport slave (
    input  opcode, ZF, in_valid, out_ready,
    output alu_func, immediate, pc_en, pc_rel_branch, reg_write, read_in,
           write_out, out_valid, in_ack, mul_start, busy, illegal_op
  );
`endif

endinterface

// File: rtl/exec_sequencer_decoder.sv
// ----------------------------------------------------------------------------
// exec_sequencer_decoder
//   Purely combinational instruction decoder.
//   i_opcode      : instruction opcode
//   i_zf          : ALU zero flag (for BEQ/BNQ)
//   o_aluFunc     : ALU function code
//   o_immediate   : ALU B operand comes from the immediate field
//   o_readIn      : regfile write data comes from the input port
//   o_regWrite    : instruction writes the regfile (ungated)
//   o_pcRelBranch : PC takes relative offset (ungated)
//   o_opClass     : instruction class used by the sequencer
// ----------------------------------------------------------------------------
module exec_sequencer_decoder
  import exec_sequencer_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic       i_zf,
  output logic [2:0] o_aluFunc,
  output logic       o_immediate,
  output logic       o_readIn,
  output logic       o_regWrite,
  output logic       o_pcRelBranch,
  output op_class_t  o_opClass
);

  // Opcode table; anything not listed is reported as illegal.
  always_comb begin
    o_aluFunc     = ALU_NONE;
    o_immediate   = 1'b0;
    o_readIn      = 1'b0;
    o_regWrite    = 1'b0;
    o_pcRelBranch = 1'b0;
    o_opClass     = CLS_ILLEGAL;
    case (i_opcode)
      OP_ADD:  begin o_aluFunc = ALU_RADD; o_regWrite = 1'b1; o_opClass = CLS_ALU; end
      OP_ADDI: begin o_aluFunc = ALU_RADD; o_immediate = 1'b1; o_regWrite = 1'b1; o_opClass = CLS_ALU; end
      OP_SUB:  begin o_aluFunc = ALU_RSUB; o_regWrite = 1'b1; o_opClass = CLS_ALU; end
      OP_SUBI: begin o_aluFunc = ALU_RSUB; o_immediate = 1'b1; o_regWrite = 1'b1; o_opClass = CLS_ALU; end
      OP_MULT: begin o_regWrite = 1'b1; o_opClass = CLS_MULT; end
      OP_BEQ:  begin o_aluFunc = ALU_RSUB; o_pcRelBranch = i_zf;  o_opClass = CLS_BRANCH; end
      OP_BNQ:  begin o_aluFunc = ALU_RSUB; o_pcRelBranch = !i_zf; o_opClass = CLS_BRANCH; end
      OP_JMP:  begin o_pcRelBranch = 1'b1; o_opClass = CLS_BRANCH; end
      OP_STIN: begin o_readIn = 1'b1; o_regWrite = 1'b1; o_opClass = CLS_STIN; end
      OP_LOUT: begin o_opClass = CLS_LOUT; end
      default: begin o_opClass = CLS_ILLEGAL; end
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// ----------------------------------------------------------------------------
// exec_sequencer
//   Multi-cycle control sequencer for the pico MIPS core. Single-cycle ops
//   complete in one cycle; MULT holds the PC for MUL_CYCLES cycles; STIN and
//   LOUT wait on the in_valid / out_ready handshakes. reg_write and pc_en are
//   asserted only in the completion cycle of each instruction.
//   Ports:
//     clk    : system clock
//     reset  : asynchronous active-high reset
//     bus    : exec_sequencer_if.slave (opcode/flags/handshakes in,
//              control strobes out)
//   Parameter MUL_CYCLES : total cycles one MULT occupies (>=1).
//   Macro SEQ_SINGLE_STEP_EN : when defined, a RUN-state instruction only
//   issues in cycles where bus.step is high; wait states finish regardless.
// ----------------------------------------------------------------------------
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  exec_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [5:0]       r_opcode;

  logic             w_inWait;
  logic [5:0]       w_opcodeEff;
  logic             w_issue;
  logic [2:0]       w_decAluFunc;
  logic             w_decImm;
  logic             w_decReadIn;
  logic             w_decRegWrite;
  logic             w_decPcRel;
  op_class_t        w_decClass;

  assign w_inWait = (r_state == MUL_WAIT) || (r_state == IN_WAIT) || (r_state == OUT_WAIT);

  // While waiting, the decoder sees the opcode captured on entry so that a
  // fetch-side opcode change cannot alter the instruction in flight.
  assign w_opcodeEff = w_inWait ? r_opcode : bus.opcode;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_issue = bus.step;
`else
  assign w_issue = 1'b1;
`endif

  exec_sequencer_decoder u_decoder (
    .i_opcode      (w_opcodeEff),
    .i_zf          (bus.ZF),
    .o_aluFunc     (w_decAluFunc),
    .o_immediate   (w_decImm),
    .o_readIn      (w_decReadIn),
    .o_regWrite    (w_decRegWrite),
    .o_pcRelBranch (w_decPcRel),
    .o_opClass     (w_decClass)
  );

  // State, MULT down-counter and latched opcode. Reset drops straight back
  // to IDLE, so no completion strobe can follow an interrupted wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEQ_IDLE_ST;
      r_cnt    <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (r_state == RUN && w_nextState != RUN)
        r_opcode <= bus.opcode;
    end
  end

  // Next-state and control outputs. Everything defaults to 0 so IDLE (and
  // therefore the reset period) drives no strobes at all.
  always_comb begin
    w_nextState       = r_state;
    w_nextCnt         = r_cnt;
    bus.alu_func      = ALU_NONE;
    bus.immediate     = 1'b0;
    bus.pc_en         = 1'b0;
    bus.pc_rel_branch = 1'b0;
    bus.reg_write     = 1'b0;
    bus.read_in       = 1'b0;
    bus.write_out     = 1'b0;
    bus.out_valid     = 1'b0;
    bus.in_ack        = 1'b0;
    bus.mul_start     = 1'b0;
    bus.busy          = w_inWait;
    bus.illegal_op    = 1'b0;

    if (r_state != IDLE) begin
      bus.alu_func  = w_decAluFunc;
      bus.immediate = w_decImm;
    end

    case (r_state)
      IDLE: w_nextState = RUN;

      RUN: begin
        if (w_issue) begin
          case (w_decClass)
            CLS_ALU: begin
              bus.pc_en     = 1'b1;
              bus.reg_write = w_decRegWrite;
            end
            CLS_BRANCH: begin
              bus.pc_en         = 1'b1;
              bus.pc_rel_branch = w_decPcRel;
            end
            CLS_MULT: begin
              bus.mul_start = 1'b1;
              if (MUL_CYCLES == 1) begin
                bus.reg_write = w_decRegWrite;
                bus.pc_en     = 1'b1;
              end else begin
                // Issue cycle counts as the first of MUL_CYCLES, and the
                // completion cycle is the one where the counter reads 0.
                w_nextCnt   = CNT_W'(MUL_CYCLES - 2);
                w_nextState = MUL_WAIT;
              end
            end
            CLS_STIN: begin
              if (bus.in_valid) begin
                bus.read_in   = w_decReadIn;
                bus.reg_write = w_decRegWrite;
                bus.in_ack    = 1'b1;
                bus.pc_en     = 1'b1;
              end else begin
                w_nextState = IN_WAIT;
              end
            end
            CLS_LOUT: begin
              bus.out_valid = 1'b1;
              if (bus.out_ready) begin
                bus.write_out = 1'b1;
                bus.pc_en     = 1'b1;
              end else begin
                w_nextState = OUT_WAIT;
              end
            end
            default: begin
              bus.pc_en      = 1'b1;
              bus.illegal_op = 1'b1;
            end
          endcase
        end
      end

      MUL_WAIT: begin
        if (r_cnt != '0) begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end else begin
          bus.reg_write = w_decRegWrite;
          bus.pc_en     = 1'b1;
          w_nextState   = RUN;
        end
      end

      IN_WAIT: begin
        if (bus.in_valid) begin
          bus.read_in   = w_decReadIn;
          bus.reg_write = w_decRegWrite;
          bus.in_ack    = 1'b1;
          bus.pc_en     = 1'b1;
          w_nextState   = RUN;
        end
      end

      OUT_WAIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          bus.write_out = 1'b1;
          bus.pc_en     = 1'b1;
          w_nextState   = RUN;
        end
      end

      default: w_nextState = IDLE;
    endcase
  end

endmodule
